pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sequences the iCE40 SB_PLL40 clock generator: drives its RESETB, supervises LOCK, releases system reset only after a stable lock plus a hold-off window.
- Retries the PLL on lock timeout; re-enters reset on lock loss or a restart request.
- Runs on the raw board oscillator clock (12 MHz), never on the PLL output. Downstream domains re-synchronize sys_reset locally.

Parameters:
- RST_CYCLES, 16, cycles pll_resetb held low per PLL reset pulse (>=2).
- LOCK_STABLE, 64, consecutive synchronized lock-high cycles required before hold-off.
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before the PLL is reset again.
- HOLD_CYCLES, 256, cycles sys_reset stays asserted after stable lock.
- CNT_W, 17, width of the shared cycle counter; must hold max(all above)-1.
- MAX_RETRIES, 7, timeout retries before fail (used only with the optional feature).

Ports:
- clock in 1: board oscillator clock.
- reset in 1: asynchronous, active-high; forces all state to reset values.
- pll_lock in 1: PLL LOCK output; asynchronous, synchronized internally.
- restart in 1: single-cycle request to re-run the full sequence, e.g. after reconfiguration.
- pll_resetb out 1: to PLL RESETB; active-low.
- sys_reset out 1: active-high system reset request.
- ready out 1: high only in RUN.
- relock_count out 8: saturating count of lock losses and timeouts.
- fail out 1: retry limit reached; constant 0 without the optional feature.
- state_dbg out 2: current state encoding.

Behaviour:
- Reset values: state=PLL_RST, counter=0, pll_resetb=0, sys_reset=1, ready=0, relock_count=0, fail=0, lock synchronizer=00.
- pll_lock passes through a 2-FF synchronizer to give lock_s; 2-cycle latency.
- All outputs are registered and decoded from next-state, so they change on the same edge the state changes.
- States and encoding: PLL_RST=0, WAIT_LOCK=1, HOLD=2, RUN=3.
- PLL_RST:
  - pll_resetb=0, sys_reset=1.
  - Counter runs 0..RST_CYCLES-1; at RST_CYCLES-1 go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - pll_resetb=1, sys_reset=1.
  - Counter counts total cycles. A separate stability counter increments while lock_s=1 and clears when lock_s=0.
  - Stability counter reaches LOCK_STABLE-1 with lock_s=1: go to HOLD.
  - Else counter reaches LOCK_TIMEOUT-1: go to PLL_RST and increment relock_count.
  - If both happen in the same cycle, HOLD wins.
- HOLD:
  - sys_reset=1; counter runs 0..HOLD_CYCLES-1, then RUN.
  - lock_s=0: go to PLL_RST and increment relock_count.
- RUN:
  - sys_reset=0, ready=1.
  - lock_s=0: go to PLL_RST next edge (sys_reset=1, ready=0) and increment relock_count.
- restart=1 in any state:
  - go to PLL_RST with counters cleared; relock_count is not incremented.
  - restart has priority over every other transition.
- relock_count saturates at 255 and never wraps; cleared only by reset.
- Held restart: the block stays in PLL_RST with the counter cleared.
- Reset asserted mid-sequence: immediate return to reset values. pll_resetb drops asynchronously.

Optional Feature:
- Macro PLLSEQ_RETRY_LIMIT_EN.
- When defined:
  - A 3-bit retry counter increments on each WAIT_LOCK timeout and clears on entering RUN.
  - On the timeout that would reach MAX_RETRIES, enter a terminal FAIL condition: state_dbg=PLL_RST, pll_resetb=0, sys_reset=1, fail=1.
  - Only reset or restart leaves FAIL; restart also clears the retry counter.
- When undefined: timeouts retry indefinitely and fail is tied to 0.

Decomposition:
- Shared package pllseq_pkg holds:
  - state encoding constants (PLL_RST, WAIT_LOCK, HOLD, RUN);
  - default timing constants;
  - the relock_count width (8).
- One sub-module, sync2: 2-FF synchronizer with asynchronous active-high reset to 0, used for pll_lock.

Test Plan:
- All tests use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, HOLD_CYCLES=16.
- Power-up, lock rises 10 cycles after pll_resetb rises and stays high:
  - pll_resetb low for exactly 4 cycles after reset deasserts;
  - ready and sys_reset=0 exactly 26 edges after the lock rise;
  - relock_count=0.
- pll_lock never rises:
  - pll_resetb pulses low for 4 cycles every 104 cycles;
  - relock_count=1,2,3... on each pulse;
  - ready stays 0.
- In RUN, pll_lock drops for 1 cycle:
  - sys_reset=1 and ready=0 on the 3rd edge after the drop;
  - relock_count increments by 1;
  - full sequence repeats.
- Lock glitches low for 1 cycle after 6 high cycles in WAIT_LOCK: the stability counter restarts, and HOLD is entered only after 8 further consecutive highs.
- restart pulse in HOLD and in RUN: PLL_RST on the next edge, relock_count unchanged, pll_resetb low 4 cycles.
- PLLSEQ_RETRY_LIMIT_EN defined, no lock:
  - fail=1 after the 7th timeout and stays there, with no further pll_resetb pulses;
  - a restart pulse clears fail and resumes sequencing.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// pllseq_pkg: state encoding, default timing constants and widths shared by
// pll_reset_sequencer and its testbench.
// Optional retry limit is enabled by defining PLLSEQ_RETRY_LIMIT_EN.
package pllseq_pkg;

   // Sequencer states; the encoding is visible on state_dbg.
   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } pllseq_state_e;

   // Default timing, in board-oscillator cycles.
   localparam int unsigned DEF_RST_CYCLES   = 16;
   localparam int unsigned DEF_LOCK_STABLE  = 64;
   localparam int unsigned DEF_LOCK_TIMEOUT = 65536;
   localparam int unsigned DEF_HOLD_CYCLES  = 256;
   localparam int unsigned DEF_CNT_W        = 17;

   // Width of the saturating relock counter.
   localparam int unsigned RELOCK_W = 8;

`ifdef PLLSEQ_RETRY_LIMIT_EN
   localparam int unsigned DEF_MAX_RETRIES = 7;
   localparam int unsigned RETRY_W         = 3;
`endif

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
      return (v == '1) ? v : v + RELOCK_W'(1);
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [1:0] ff_d;
   logic [1:0] ff_q;

   // Shift the raw input through two stages.
   always_comb begin
      ff_d = {ff_q[0], d};
   end

   // Synchronizer flops; asynchronous reset clears both stages.
   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) ff_q <= '0;
      else       ff_q <= ff_d;
   end

   assign q = ff_q[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives SB_PLL40 RESETB, supervises LOCK and releases
// sys_reset only after a stable lock plus a hold-off window. Runs on the raw
// oscillator clock. Optional retry limit: define PLLSEQ_RETRY_LIMIT_EN.
module pll_reset_sequencer
   import pllseq_pkg::*;
#(
   parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
   parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int unsigned CNT_W        = DEF_CNT_W
`ifdef PLLSEQ_RETRY_LIMIT_EN
   ,
   parameter int unsigned MAX_RETRIES  = DEF_MAX_RETRIES
`endif
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                pll_lock,
   input  logic                restart,
   output logic                pll_resetb,
   output logic                sys_reset,
   output logic                ready,
   output logic [RELOCK_W-1:0] relock_count,
   output logic                fail,
   output logic [1:0]          state_dbg
);

   // Terminal counter values for each timed phase.
   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

   pllseq_state_e       state_d, state_q;
   logic [CNT_W-1:0]    cnt_d, cnt_q;        // shared phase counter
   logic [CNT_W-1:0]    stab_d, stab_q;      // consecutive lock-high cycles
   logic [RELOCK_W-1:0] relock_d, relock_q;
   logic                relock_inc;
   logic                pll_resetb_d, pll_resetb_q;
   logic                sys_reset_d, sys_reset_q;
   logic                ready_d, ready_q;
   logic                lock_s;

`ifdef PLLSEQ_RETRY_LIMIT_EN
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
   logic [RETRY_W-1:0] retry_d, retry_q;
   logic               fail_d, fail_q;
`endif

   sync2 u_lock_sync (
      .clock (clock),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // State register plus registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= PLL_RST;
         cnt_q        <= '0;
         stab_q       <= '0;
         relock_q     <= '0;
         pll_resetb_q <= 1'b0;
         sys_reset_q  <= 1'b1;
         ready_q      <= 1'b0;
`ifdef PLLSEQ_RETRY_LIMIT_EN
         retry_q      <= '0;
         fail_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stab_q       <= stab_d;
         relock_q     <= relock_d;
         pll_resetb_q <= pll_resetb_d;
         sys_reset_q  <= sys_reset_d;
         ready_q      <= ready_d;
`ifdef PLLSEQ_RETRY_LIMIT_EN
         retry_q      <= retry_d;
         fail_q       <= fail_d;
`endif
      end
   end

   // Next-state logic: restart first, then the terminal fail hold, then the FSM.
   always_comb begin
      // NOTE: every variable gets a default before the branches so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      stab_d     = '0;
      relock_inc = 1'b0;
`ifdef PLLSEQ_RETRY_LIMIT_EN
      retry_d    = retry_q;
      fail_d     = fail_q;
`endif
      if (restart) begin
         state_d = PLL_RST;
         cnt_d   = '0;
`ifdef PLLSEQ_RETRY_LIMIT_EN
         retry_d = '0;
         fail_d  = 1'b0;
`endif
      end
`ifdef PLLSEQ_RETRY_LIMIT_EN
      else if (fail_q) begin
         // Parked with the PLL held in reset until restart or reset.
         state_d = PLL_RST;
         cnt_d   = '0;
      end
`endif
      else begin
         case (state_q)
            PLL_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end
            end
            WAIT_LOCK: begin
               stab_d = lock_s ? stab_q + CNT_W'(1) : '0;
               // A stable lock beats a simultaneous timeout.
               if (lock_s && (stab_q == STABLE_LAST)) begin
                  state_d = HOLD;
                  cnt_d   = '0;
                  stab_d  = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d    = PLL_RST;
                  cnt_d      = '0;
                  relock_inc = 1'b1;
`ifdef PLLSEQ_RETRY_LIMIT_EN
                  retry_d = retry_q + RETRY_W'(1);
                  if (retry_q == RETRY_LAST) fail_d = 1'b1;
`endif
               end
            end
            HOLD: begin
               if (!lock_s) begin
                  state_d    = PLL_RST;
                  cnt_d      = '0;
                  relock_inc = 1'b1;
               end else if (cnt_q == HOLD_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
`ifdef PLLSEQ_RETRY_LIMIT_EN
                  retry_d = '0;
`endif
               end
            end
            RUN: begin
               cnt_d = '0;
               if (!lock_s) begin
                  state_d    = PLL_RST;
                  relock_inc = 1'b1;
               end
            end
            default: begin
               state_d = PLL_RST;
               cnt_d   = '0;
            end
         endcase
      end
      relock_d = relock_inc ? sat_inc(relock_q) : relock_q;
   end

   // Output decode from the next state so outputs move on the state edge.
   always_comb begin
      pll_resetb_d = (state_d != PLL_RST);
      sys_reset_d  = (state_d != RUN);
      ready_d      = (state_d == RUN);
   end

   assign pll_resetb   = pll_resetb_q;
   assign sys_reset    = sys_reset_q;
   assign ready        = ready_q;
   assign relock_count = relock_q;
   assign state_dbg    = state_q;
`ifdef PLLSEQ_RETRY_LIMIT_EN
   assign fail         = fail_q;
`else
   assign fail         = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed stimulus with a scoreboard of expected
// output-change events (cycle number plus full output snapshot). A monitor
// samples on the falling edge and pops one expectation per observed change.
module tb_pll_reset_sequencer;

   localparam int ST_RST  = 0;
   localparam int ST_WAIT = 1;
   localparam int ST_HOLD = 2;
   localparam int ST_RUN  = 3;

   logic       clock    = 1'b0;
   logic       reset    = 1'b1;
   logic       pll_lock = 1'b0;
   logic       restart  = 1'b0;
   logic       pll_resetb, sys_reset, ready, fail;
   logic [7:0] relock_count;
   logic [1:0] state_dbg;

   pll_reset_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_STABLE  (8),
      .LOCK_TIMEOUT (100),
      .HOLD_CYCLES  (16),
      .CNT_W        (17)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .pll_lock     (pll_lock),
      .restart      (restart),
      .pll_resetb   (pll_resetb),
      .sys_reset    (sys_reset),
      .ready        (ready),
      .relock_count (relock_count),
      .fail         (fail),
      .state_dbg    (state_dbg)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   typedef struct packed {
      logic       prb;
      logic       sr;
      logic       rdy;
      logic [7:0] rc;
      logic [1:0] st;
      logic       fl;
   } snap_t;

   typedef struct {
      int    cyc;
      snap_t s;
      string name;
   } ev_t;

   ev_t   exp_q[$];
   snap_t cur, prev;
   ev_t   e;
   bit    mon_en  = 1'b0;
   int    n_checks = 0;
   int    n_pass   = 0;

   function automatic string fmt(input int c, input snap_t s);
      return $sformatf("cyc=%0d resetb=%b sys_reset=%b ready=%b relock=%0d state=%0d fail=%b",
                       c, s.prb, s.sr, s.rdy, s.rc, s.st, s.fl);
   endfunction

   task automatic check(input bit ok, input string name, input string act, input string req);
      n_checks++;
      if (ok) n_pass++;
      else    $display("FAIL %s: got %s, expected %s", name, act, req);
   endtask

   task automatic ev(input int c, input bit prb, input bit sr, input bit rdy,
                     input int rc, input int st, input bit fl, input string nm);
      ev_t x;
      x.cyc    = c;
      x.s.prb  = prb;
      x.s.sr   = sr;
      x.s.rdy  = rdy;
      x.s.rc   = 8'(rc);
      x.s.st   = 2'(st);
      x.s.fl   = fl;
      x.name   = nm;
      exp_q.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) tick(1);
   endtask

   // Monitor: every change of the output snapshot must match the next expectation.
   always @(negedge clock) begin
      if (mon_en) begin
         cur.prb = pll_resetb;
         cur.sr  = sys_reset;
         cur.rdy = ready;
         cur.rc  = relock_count;
         cur.st  = state_dbg;
         cur.fl  = fail;
         if (cur !== prev) begin
            prev = cur;
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_change", fmt(cyc, cur), "no change");
            end else begin
               e = exp_q.pop_front();
               check((cyc == e.cyc) && (cur === e.s), e.name, fmt(cyc, cur), fmt(e.cyc, e.s));
            end
         end
      end
   end

   int b, b2, w, r, w0, last;

   initial begin
      // Reset state.
      tick(3);
      prev   = 'x;
      mon_en = 1'b1;
      ev(cyc, 0, 1, 0, 0, ST_RST, 0, "reset_state");
      tick(1);
      reset = 1'b0;
      b = cyc;

      // Power-up with lock rising 10 cycles after pll_resetb rises.
      ev(b + 4,  1, 1, 0, 0, ST_WAIT, 0, "pup_resetb_release");
      ev(b + 24, 1, 1, 0, 0, ST_HOLD, 0, "pup_hold");
      ev(b + 40, 1, 0, 1, 0, ST_RUN,  0, "pup_run");
      wait_cyc(b + 14);
      pll_lock = 1'b1;

      // One-cycle lock drop in RUN.
      ev(b + 48, 0, 1, 0, 1, ST_RST,  0, "drop_reset");
      ev(b + 52, 1, 1, 0, 1, ST_WAIT, 0, "drop_wait");
      ev(b + 60, 1, 1, 0, 1, ST_HOLD, 0, "drop_hold");
      ev(b + 76, 1, 0, 1, 1, ST_RUN,  0, "drop_run");
      wait_cyc(b + 45);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;

      // Restart in RUN, then restart in HOLD.
      ev(b + 81,  0, 1, 0, 1, ST_RST,  0, "restart_run_reset");
      ev(b + 85,  1, 1, 0, 1, ST_WAIT, 0, "restart_run_wait");
      ev(b + 93,  1, 1, 0, 1, ST_HOLD, 0, "restart_run_hold");
      ev(b + 96,  0, 1, 0, 1, ST_RST,  0, "restart_hold_reset");
      ev(b + 100, 1, 1, 0, 1, ST_WAIT, 0, "restart_hold_wait");
      ev(b + 108, 1, 1, 0, 1, ST_HOLD, 0, "restart_hold_hold");
      ev(b + 124, 1, 0, 1, 1, ST_RUN,  0, "restart_hold_run");
      wait_cyc(b + 80);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      wait_cyc(b + 95);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;

      // Lock lost for good in RUN.
      ev(b + 133, 0, 1, 0, 2, ST_RST,  0, "loss_reset");
      ev(b + 137, 1, 1, 0, 2, ST_WAIT, 0, "loss_wait");
      wait_cyc(b + 130);
      pll_lock = 1'b0;

      // Glitch after 6 synchronized highs restarts the stability count.
      b2 = b + 137;
      ev(b2 + 17, 1, 1, 0, 2, ST_HOLD, 0, "glitch_hold");
      ev(b2 + 23, 0, 1, 0, 3, ST_RST,  0, "hold_loss_reset");
      ev(b2 + 27, 1, 1, 0, 3, ST_WAIT, 0, "hold_loss_wait");
      wait_cyc(b2);
      pll_lock = 1'b1;
      wait_cyc(b2 + 6);
      pll_lock = 1'b0;
      wait_cyc(b2 + 7);
      pll_lock = 1'b1;
      wait_cyc(b2 + 20);
      pll_lock = 1'b0;

      // No lock: timeout every 104 cycles with relock_count climbing.
      w = b2 + 27;
      ev(w + 100, 0, 1, 0, 4, ST_RST,  0, "timeout1_reset");
      ev(w + 104, 1, 1, 0, 4, ST_WAIT, 0, "timeout1_wait");
      ev(w + 204, 0, 1, 0, 5, ST_RST,  0, "timeout2_reset");
      ev(w + 208, 1, 1, 0, 5, ST_WAIT, 0, "timeout2_wait");
      ev(w + 308, 0, 1, 0, 6, ST_RST,  0, "timeout3_reset");
      ev(w + 312, 1, 1, 0, 6, ST_WAIT, 0, "timeout3_wait");

      // Asynchronous reset mid-sequence shows before the next clock edge.
      ev(w + 350, 0, 1, 0, 0, ST_RST, 0, "async_reset");
      wait_cyc(w + 350);
      reset = 1'b1;
      wait_cyc(w + 352);
      reset = 1'b0;
      r = w + 352;

      // Held restart keeps the counter cleared.
      ev(r + 4,  1, 1, 0, 0, ST_WAIT, 0, "rerun_wait");
      ev(r + 11, 0, 1, 0, 0, ST_RST,  0, "held_restart_reset");
      ev(r + 20, 1, 1, 0, 0, ST_WAIT, 0, "held_restart_wait");
      wait_cyc(r + 10);
      restart = 1'b1;
      wait_cyc(r + 16);
      restart = 1'b0;
      w0 = r + 20;

`ifdef PLLSEQ_RETRY_LIMIT_EN
      // Retry limit: the 7th timeout parks in fail until restart.
      for (int k = 1; k <= 6; k++) begin
         ev(w0 + 104 * (k - 1) + 100, 0, 1, 0, k, ST_RST,  0, "retry_reset");
         ev(w0 + 104 * k,             1, 1, 0, k, ST_WAIT, 0, "retry_wait");
      end
      ev(w0 + 724,  0, 1, 0, 7, ST_RST,  1, "fail_set");
      ev(w0 + 1001, 0, 1, 0, 7, ST_RST,  0, "fail_clear");
      ev(w0 + 1005, 1, 1, 0, 7, ST_WAIT, 0, "fail_resume");
      wait_cyc(w0 + 1000);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      last = w0 + 1005;
`else
      // Saturation: relock_count sticks at 255 while timeouts continue.
      for (int k = 1; k <= 257; k++) begin
         ev(w0 + 104 * (k - 1) + 100, 0, 1, 0, (k > 255) ? 255 : k, ST_RST,  0, "sat_reset");
         ev(w0 + 104 * k,             1, 1, 0, (k > 255) ? 255 : k, ST_WAIT, 0, "sat_wait");
      end
      last = w0 + 104 * 257;
`endif

      wait_cyc(last + 5);
      check(exp_q.size() == 0, "events_outstanding",
            $sformatf("%0d left", exp_q.size()), "0 left");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
